// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux: reset, redirect, hold or increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_en_i,
  input  logic                 advance_i,
  input  logic [PC_W-1:2]      target_i,
  output logic [PC_W-1:0]      pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect targets are forced word-aligned; the increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en_i) begin
      pc_d = {target_i, 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the ROM address and fills the IF/ID register,
// handling stall, redirect bubbles, sticky halt and fetch counting.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [15:0]      redirect_pc,
  input  logic             halt,
  output logic [15:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [15:0]      if_id_pc,
  output logic [15:0]      if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err
);

  fetch_state_e     state_q;
  logic [15:0]      pc;
  logic [15:0]      if_id_pc_q;
  logic [15:0]      if_id_pc4_q;
  logic [31:0]      if_id_instr_q;
  logic             if_id_valid_q;
  logic [CNT_W-1:0] fetch_count_q;
  logic             misalign_err_q;
  logic             redirect_take;
  logic             advance;

  // Redirect is honoured from BOOT or RUN unless halt outranks it.
  assign redirect_take = redirect_valid && !halt && (state_q != HALT);
  assign advance       = (state_q == RUN) && !halt && !redirect_valid && !stall;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_en_i (redirect_take),
    .advance_i     (advance),
    .target_i      (redirect_pc[15:2]),
    .pc_o          (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      if_id_pc_q     <= 16'h0000;
      if_id_pc4_q    <= 16'h0000;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      fetch_count_q  <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= halt ? HALT : RUN;
          if_id_instr_q <= NOP_INSTR;
          if_id_valid_q <= 1'b0;
          if (redirect_take && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state_q       <= HALT;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
          end else if (redirect_valid) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
              misalign_err_q <= 1'b1;
            end
          end else if (!stall) begin
            if_id_instr_q <= imem_instr;
            if_id_pc_q    <= pc;
            if_id_pc4_q   <= pc + PC_INC;
            if_id_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_q + 1'b1;
          end
        end
        HALT: begin
          if_id_instr_q <= NOP_INSTR;
          if_id_valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr    = pc;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign fetch_count  = fetch_count_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts the state after
// each edge, and a monitor compares the DUT one time-step after that edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ifpc;
    logic [15:0] ifpc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: mode 0 = just reset, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [15:0] m_pc = 16'h0000;
  exp_t        m;

  fetch_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (NOP),
    .CNT_W     (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // ROM: every word is its own address tagged with 0xA000 in the upper half.
  assign imem_instr = {16'hA000, imem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the coming edge, queue the result.
  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [15:0] rp, input logic h);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp; halt = h;
    if (r) begin
      m_mode = 0; m_pc = 16'h0000;
      m.ifpc = 16'h0000; m.ifpc4 = 16'h0000; m.instr = NOP;
      m.valid = 1'b0; m.cnt = 0; m.mis = 1'b0;
    end else if (m_mode == 2) begin
      m.instr = NOP; m.valid = 1'b0;
    end else if (h) begin
      m_mode = 2; m.instr = NOP; m.valid = 1'b0;
    end else if (rv) begin
      m_mode = 1;
      m_pc = rp & 16'hFFFC;
      m.instr = NOP; m.valid = 1'b0;
      if (rp % 4 != 0) m.mis = 1'b1;
    end else if (m_mode == 0) begin
      m_mode = 1; m.instr = NOP; m.valid = 1'b0;
    end else if (!s) begin
      m.instr = 32'hA000_0000 + {16'h0000, m_pc};
      m.ifpc  = m_pc;
      m.ifpc4 = 16'((32'(m_pc) + 4) % 65536);
      m.valid = 1'b1;
      m.cnt   = m.cnt + 1;
      m_pc    = 16'((32'(m_pc) + 4) % 65536);
    end
    m.pc = m_pc;
    exp_q.push_back(m);
    $display("[TB] step rst=%0b stall=%0b redir=%0b rpc=%h halt=%0b -> pc=%h if_id_pc=%h valid=%0b cnt=%0d",
             r, s, rv, rp, h, m.pc, m.ifpc, m.valid, m.cnt);
  endtask

  // Monitor: every edge with a pending expectation is checked one step later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr",    {16'h0, imem_addr},   {16'h0, e.pc});
        chk("if_id_pc",     {16'h0, if_id_pc},    {16'h0, e.ifpc});
        chk("if_id_pc4",    {16'h0, if_id_pc4},   {16'h0, e.ifpc4});
        chk("if_id_instr",  if_id_instr,          e.instr);
        chk("if_id_valid",  {31'h0, if_id_valid}, {31'h0, e.valid});
        chk("fetch_count",  fetch_count,          e.cnt);
        chk("misalign_err", {31'h0, misalign_err},{31'h0, e.mis});
      end
    end
  end

  initial begin
    logic [15:0] rp;
    int          sel;
    // Reset, boot bubble, then free-run to pc=0x10.
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 0);
    // Three stall cycles at 0x10, release, run to 0x20.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 0);
    // Redirect with simultaneous stall.
    step(0, 1, 1, 16'h0008, 0);
    step(0, 0, 0, 16'h0, 0);
    // Misaligned redirect, then normal fetches keep the sticky flag.
    step(0, 0, 1, 16'h0046, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0);
    // Wrap at the top of the address space.
    step(0, 0, 1, 16'hFFFC, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0);
    // Halt, sit halted with activity on inputs, then reset out of it.
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0100, 0);
    step(0, 1, 0, 16'h0, 0);
    step(1, 1, 1, 16'h0200, 1);
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    // Boot-time corner cases: redirect during BOOT, halt during BOOT.
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0131, 0);
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      rp = 16'($urandom);
      else if (sel == 1) rp = 16'hFFF0 | 16'($urandom_range(0, 15));
      else               rp = 16'($urandom_range(0, 255));
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rp, $urandom_range(0, 199) == 0);
    end
    step(0, 0, 0, 16'h0, 0);
    // Drain: every queued expectation must have been checked within a bounded time.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
